// File: rtl/pc_gen_ras.sv
// Fetch-stage program-counter generator: sequential increment, stall hold,
// redirect, trap vectoring and a circular return-address stack for call/return.
module pc_gen_ras #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = 'h100,
  parameter int              INC       = 4,
  parameter int              RAS_DEPTH = 4,
  localparam int             AW        = $clog2(RAS_DEPTH),
  localparam int             CW        = AW + 1
) (
  input  logic            i_CLK,
  input  logic            i_RST,
  input  logic            i_stall,
  input  logic            i_trap,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_target,
  input  logic            i_call,
  input  logic            i_ret,
  output logic [XLEN-1:0] o_pc,
  output logic [CW-1:0]   o_ras_count,
  output logic            o_ras_ovf,
  output logic            o_misalign
);

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INC - 1);
  localparam logic [CW-1:0]   FULL     = CW'(RAS_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];

  logic            wr_en;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   top_idx;
  logic [XLEN-1:0] link;
  logic [XLEN-1:0] tgt_al;
  logic            tgt_mis;
  logic            ras_empty;

  // ptr_q is the next free slot; the top of stack sits one below it.
  assign top_idx   = ptr_q - AW'(1);
  assign link      = pc_q + XLEN'(INC);
  assign tgt_al    = i_target & ~LOW_MASK;
  assign tgt_mis   = |(i_target & LOW_MASK);
  assign ras_empty = (cnt_q == '0);

  always_comb begin
    pc_d   = pc_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    mis_d  = 1'b0;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (i_trap) begin
      pc_d = TRAP_VEC;
    end else if (i_ret) begin
      if (!ras_empty) begin
        pc_d = ras_q[top_idx];
        // A simultaneous call replaces the popped entry in place.
        if (i_call) begin
          wr_en  = 1'b1;
          wr_idx = top_idx;
        end else begin
          ptr_d = top_idx;
          cnt_d = cnt_q - CW'(1);
        end
      end else begin
        pc_d  = tgt_al;
        mis_d = tgt_mis;
        if (i_call) begin
          wr_en = 1'b1;
          ptr_d = ptr_q + AW'(1);
          cnt_d = CW'(1);
        end
      end
    end else if (i_redirect) begin
      pc_d  = tgt_al;
      mis_d = tgt_mis;
      if (i_call) begin
        wr_en = 1'b1;
        ptr_d = ptr_q + AW'(1);
        // When full the write lands on the oldest entry; count saturates.
        if (cnt_q == FULL) ovf_d = 1'b1;
        else               cnt_d = cnt_q + CW'(1);
      end
    end else if (!i_stall) begin
      pc_d = link;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      pc_q  <= RESET_VEC;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      mis_q <= mis_d;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST && wr_en) ras_q[wr_idx] <= link;
  end

  assign o_pc        = pc_q;
  assign o_ras_count = cnt_q;
  assign o_ras_ovf   = ovf_q;
  assign o_misalign  = mis_q;

endmodule
